jtframe_pocket_dwnld: RTL and testbench
=======================================

# jtframe_pocket_dwnld

Converts Analogue Pocket bridge write traffic into the byte-wide ioctl download stream consumed by the Pocket framework top level and the game's ROM loader. Sits upstream of the Pocket base/board stage:
- 32-bit big-endian bridge words are buffered in a small FIFO.
- Each word is serialised into four paced `ioctl_wr` byte strobes.
- The block also provides a control/status register readable over the bridge.

Bridge signals arrive already synchronised to `clk`.

## Interface
Parameters
- `FIFOW`, 2: log2 of FIFO depth in 32-bit words (depth 4).
- `WR_GAP`, 3: idle cycles after each `ioctl_wr` pulse.
- `DATA_NIB`, 4'h0: `bridge_addr[31:28]` value selecting the ROM data window.
- `CTRL_ADDR`, 32'hF000_0000: control/status register address.

Ports
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `bridge_addr`  in  32  bridge byte address.
- `bridge_wr`  in  1  one-cycle write strobe.
- `bridge_wr_data`  in  32  write data; big-endian byte order.
- `bridge_rd`  in  1  one-cycle read strobe.
- `bridge_rd_data`  out  32  registered read data.
- `ioctl_addr`  out  25  byte address of the current `ioctl_dout`.
- `ioctl_dout`  out  8  download byte.
- `ioctl_wr`  out  1  one-cycle byte strobe.
- `ioctl_ram`  out  1  copy of control bit 1.
- `downloading`  out  1  high while a download is active or draining.

## Operation
Control register (`CTRL_ADDR`)
- Write:
  - bit0 = `act`. A 0→1 transition clears the `ovf` flag and the checksum.
  - bit1 = `ram`, driven to `ioctl_ram`.
- Read, bit layout:
  - [0] `act`, [1] `ram`, [2] `downloading`
  - [3] FIFO empty, [4] FIFO full, [5] `ovf` (sticky overflow), [31:6] 0.

Data writes
- A data write is a bridge write with `addr[31:28]==DATA_NIB` and `downloading==1`.
- It pushes `{addr[24:2], data}` into the FIFO.
- Data writes while `downloading==0` are ignored.
- Push when full is dropped and sets `ovf`. If a pop occurs in the same cycle, the push is accepted.

Serialiser FSM
- IDLE: if the FIFO is not empty → LOAD.
- LOAD: pops a word, sets k=0 → EMIT.
- EMIT: drives `ioctl_wr=1` for one cycle with:
  - `ioctl_dout` = byte k of the word, where k=0 is `data[31:24]` (big-endian).
  - `ioctl_addr` = `{addr[24:2],2'b00}+k`.
  - Then → GAP.
- GAP: counts `WR_GAP` cycles. If k<3: k++, → EMIT. Else → IDLE.
- `WR_GAP=0`: GAP lasts zero cycles, giving back-to-back strobes.
- `ioctl_addr` and `ioctl_dout` hold their values until the next EMIT.

`downloading`
- Set the cycle after `act` is written 1.
- Cleared when all of the following hold: `act==0`, FIFO empty, FSM in IDLE.
- Re-asserting `act` while draining keeps it high with no glitch.

Reads
- Any address other than `CTRL_ADDR` (and `CTRL_ADDR+4` when the checksum is configured in) returns 0.

## Timing
- Reset values:
  - all outputs 0; FIFO empty; FSM IDLE; `act`, `ram`, `ovf` = 0; checksum 0.
- Reset asserted mid-download aborts immediately. No further `ioctl_wr` is produced.
- Latency: data write at edge N into an empty FIFO → LOAD at N+1 → first `ioctl_wr` high during cycle N+2.
- Byte period is `WR_GAP+1` cycles; word period is `4*(WR_GAP+1)`.
- `bridge_rd_data` is valid the cycle after `bridge_rd` and holds until the next `bridge_rd`.
- Same-cycle control write and data write: the control write takes effect first. The data write is qualified by the pre-write `downloading` value.
- FIFO pointers wrap modulo depth. Count range is 0..2^FIFOW.

## Configuration
- `JTFRAME_POCKET_DWNLD_CHKSUM_EN` defined:
  - A 16-bit wrapping sum of every emitted byte, updated on each `ioctl_wr`.
  - Readable at `CTRL_ADDR+4` in bits [15:0].
  - Cleared on `act` 0→1.
- Undefined: no checksum logic; `CTRL_ADDR+4` reads 0.

## Test plan
- Reset, then write `CTRL_ADDR`=1, then data write 0x0000_0104 = 0xA1B2C3D4. Required with `WR_GAP=3`:
  - `ioctl_wr` pulses 2, 6, 10, 14 cycles after the data write.
  - Bytes A1/B2/C3/D4 at addresses 0x104/0x105/0x106/0x107.
- Data write with `downloading`=0 → no `ioctl_wr`; status read returns 0x08.
- Five back-to-back data writes with depth 4 and no pop yet:
  - 4 queued, 1 dropped; status bit5=1.
  - Next `act` 0→1 clears `ovf`.
- Write `act`=0 while 3 words are queued:
  - `downloading` stays 1 until the 12th byte's GAP ends, then drops.
  - Status reads 0x08 (ram=0).
- Assert `rst_n`=0 during EMIT of word 2:
  - Outputs go 0 asynchronously.
  - After release, FIFO empty and no strobes.
- With the CHKSUM macro, stream words 0x01020304 and 0xFFFFFFFF → `CTRL_ADDR+4` reads 0x0406.

Source files
------------

// File: rtl/jtframe_pocket_dwnld.sv
// Analogue Pocket bridge-to-ioctl downloader: buffers 32-bit big-endian bridge words
// and replays them as paced byte strobes. Optional checksum: JTFRAME_POCKET_DWNLD_CHKSUM_EN.
module jtframe_pocket_dwnld #(
    parameter int          FIFOW     = 2,
    parameter int          WR_GAP    = 3,
    parameter logic [3:0]  DATA_NIB  = 4'h0,
    parameter logic [31:0] CTRL_ADDR = 32'hF000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] bridge_addr,
    input  logic        bridge_wr,
    input  logic [31:0] bridge_wr_data,
    input  logic        bridge_rd,
    output logic [31:0] bridge_rd_data,
    output logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_dout,
    output logic        ioctl_wr,
    output logic        ioctl_ram,
    output logic        downloading
);
    localparam int DEPTH = 1 << FIFOW;
    localparam int GW    = (WR_GAP > 0) ? $clog2(WR_GAP + 1) : 1;
    localparam logic [FIFOW:0]   DEPTH_V  = (FIFOW+1)'(DEPTH);
    localparam logic [FIFOW-1:0] PTR_ONE  = 1;
    localparam logic [FIFOW:0]   CNT_ONE  = 1;
    localparam logic [GW-1:0]    GAP_ONE  = 1;
    localparam logic [GW-1:0]    GAP_LOAD = GW'((WR_GAP > 0) ? WR_GAP - 1 : 0);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_EMIT = 2'd2, ST_GAP = 2'd3} state_t;

    logic [54:0]      r_mem [DEPTH];
    logic [FIFOW-1:0] r_wp, r_rp;
    logic [FIFOW:0]   r_cnt;
    state_t           r_st;
    logic [1:0]       r_k;
    logic [GW-1:0]    r_gap;
    logic [54:0]      r_word;
    logic             r_act, r_ram, r_ovf, r_dl, r_ioctl_wr;
    logic [24:0]      r_ioctl_addr;
    logic [7:0]       r_ioctl_dout;
    logic [31:0]      r_rd_data;
    logic [15:0]      r_chk;

    logic w_ctrl_wr, w_act_rise, w_act_next, w_push_req, w_push, w_pop, w_empty, w_full;
    logic w_gap_done, w_word_done, w_next_byte, w_emit, w_ovf_evt, w_idle_next, w_dl_clear;
    logic [54:0] w_src_word;
    logic [1:0]  w_src_k;

    function automatic logic [7:0] byte_sel(input logic [31:0] d, input logic [1:0] k);
        case (k)
            2'd0:    byte_sel = d[31:24];
            2'd1:    byte_sel = d[23:16];
            2'd2:    byte_sel = d[15:8];
            default: byte_sel = d[7:0];
        endcase
    endfunction

    assign w_ctrl_wr   = bridge_wr && (bridge_addr == CTRL_ADDR);
    assign w_act_next  = w_ctrl_wr ? bridge_wr_data[0] : r_act;
    assign w_act_rise  = w_ctrl_wr && bridge_wr_data[0] && !r_act;
    // Data writes are qualified by the pre-write downloading flag
    assign w_push_req  = bridge_wr && (bridge_addr[31:28] == DATA_NIB) && r_dl;
    assign w_empty     = (r_cnt == '0);
    assign w_full      = (r_cnt == DEPTH_V);
    assign w_gap_done  = ((r_st == ST_GAP) && (r_gap == '0)) || ((WR_GAP == 0) && (r_st == ST_EMIT));
    assign w_word_done = w_gap_done && (r_k == 2'd3);
    assign w_next_byte = w_gap_done && (r_k != 2'd3);
    // Chained load at the end of a word keeps the word period at four byte periods
    assign w_pop       = !w_empty && ((r_st == ST_LOAD) || w_word_done);
    assign w_push      = w_push_req && (!w_full || w_pop);
    assign w_ovf_evt   = w_push_req && !w_push;
    assign w_emit      = w_pop || w_next_byte;
    assign w_src_word  = w_pop ? r_mem[r_rp] : r_word;
    assign w_src_k     = w_pop ? 2'd0 : (r_k + 2'd1);
    assign w_idle_next = (r_st == ST_IDLE) || (w_word_done && w_empty);
    assign w_dl_clear  = !w_act_next && w_empty && !w_push && w_idle_next;

    // FIFO storage, no reset needed on the data array
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= {bridge_addr[24:2], bridge_wr_data};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + PTR_ONE;
            if (w_pop)  r_rp <= r_rp + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_ONE;
                2'b01:   r_cnt <= r_cnt - CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Serialiser FSM with registered byte outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st         <= ST_IDLE;
            r_k          <= 2'd0;
            r_gap        <= '0;
            r_word       <= '0;
            r_ioctl_wr   <= 1'b0;
            r_ioctl_addr <= 25'd0;
            r_ioctl_dout <= 8'd0;
        end else begin
            r_ioctl_wr <= w_emit;
            if (w_emit) begin
                r_k          <= w_src_k;
                r_ioctl_dout <= byte_sel(w_src_word[31:0], w_src_k);
                r_ioctl_addr <= {w_src_word[54:32], 2'b00} + {23'd0, w_src_k};
            end
            if (w_pop) r_word <= r_mem[r_rp];
            case (r_st)
                ST_IDLE: if (!w_empty) r_st <= ST_LOAD;
                ST_LOAD: r_st <= ST_EMIT;
                ST_EMIT: begin
                    if (WR_GAP == 0) begin
                        r_st <= w_emit ? ST_EMIT : ST_IDLE;
                    end else begin
                        r_gap <= GAP_LOAD;
                        r_st  <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_gap == '0) r_st <= w_emit ? ST_EMIT : ST_IDLE;
                    else             r_gap <= r_gap - GAP_ONE;
                end
                default: r_st <= ST_IDLE;
            endcase
        end
    end

    // Control flags and the downloading indicator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act <= 1'b0;
            r_ram <= 1'b0;
            r_ovf <= 1'b0;
            r_dl  <= 1'b0;
        end else begin
            r_act <= w_act_next;
            if (w_ctrl_wr) r_ram <= bridge_wr_data[1];
            r_ovf <= (w_act_rise ? 1'b0 : r_ovf) | w_ovf_evt;
            if (w_act_next)      r_dl <= 1'b1;
            else if (w_dl_clear) r_dl <= 1'b0;
        end
    end

`ifdef JTFRAME_POCKET_DWNLD_CHKSUM_EN
    // Wrapping sum of every emitted byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_chk <= 16'd0;
        else if (w_act_rise) r_chk <= 16'd0;
        else if (r_ioctl_wr) r_chk <= r_chk + {8'd0, r_ioctl_dout};
    end
`else
    assign r_chk = 16'd0;
`endif

    // Registered bridge read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= 32'd0;
        end else if (bridge_rd) begin
            if (bridge_addr == CTRL_ADDR)
                r_rd_data <= {26'd0, r_ovf, w_full, w_empty, r_dl, r_ram, r_act};
`ifdef JTFRAME_POCKET_DWNLD_CHKSUM_EN
            else if (bridge_addr == CTRL_ADDR + 32'd4)
                r_rd_data <= {16'd0, r_chk};
`endif
            else
                r_rd_data <= 32'd0;
        end
    end

    assign bridge_rd_data = r_rd_data;
    assign ioctl_addr     = r_ioctl_addr;
    assign ioctl_dout     = r_ioctl_dout;
    assign ioctl_wr       = r_ioctl_wr;
    assign ioctl_ram      = r_ram;
    assign downloading    = r_dl;
endmodule

// File: tb/tb_jtframe_pocket_dwnld.sv
// Directed bench for jtframe_pocket_dwnld: register table plus timed serialiser sequences.
module tb_jtframe_pocket_dwnld;
    localparam logic [31:0] CTRL = 32'hF000_0000;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] bridge_addr = 32'd0, bridge_wr_data = 32'd0, bridge_rd_data;
    logic        bridge_wr = 1'b0, bridge_rd = 1'b0;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wr, ioctl_ram, downloading;

    jtframe_pocket_dwnld dut (
        .clk(clk), .rst_n(rst_n), .bridge_addr(bridge_addr), .bridge_wr(bridge_wr),
        .bridge_wr_data(bridge_wr_data), .bridge_rd(bridge_rd), .bridge_rd_data(bridge_rd_data),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
        .ioctl_ram(ioctl_ram), .downloading(downloading)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int c; logic [24:0] a; logic [7:0] d; } strobe_t;
    strobe_t q[$];
    always @(negedge clk) if (ioctl_wr) q.push_back('{cyc, ioctl_addr, ioctl_dout});

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_rd;
        logic        exp_ram;
        logic        exp_dl;
    } vec_t;
    vec_t tbl[11];

    int checks = 0, errors = 0;
    logic [31:0] ed[8];
    logic [24:0] ea[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic bwrite(input logic [31:0] a, input logic [31:0] d);
        bridge_addr = a; bridge_wr_data = d; bridge_wr = 1'b1;
        tick(1);
        bridge_wr = 1'b0;
    endtask

    task automatic bread(input logic [31:0] a, output logic [31:0] v);
        bridge_addr = a; bridge_rd = 1'b1;
        tick(1);
        bridge_rd = 1'b0;
        v = bridge_rd_data;
    endtask

    // Strobe j of a stream whose first word was written at edge base lands at base+2+4j
    task automatic check_stream(input string nm, input int base, input int nw);
        logic [31:0] w;
        chk({nm, " count"}, 32'(q.size()), 32'(4 * nw));
        for (int i = 0; i < 4 * nw && i < q.size(); i++) begin
            w = ed[i / 4] >> (8 * (3 - (i % 4)));
            chk($sformatf("%s cyc[%0d]", nm, i), 32'(q[i].c), 32'(base + 2 + 4 * i));
            chk($sformatf("%s addr[%0d]", nm, i), {7'd0, q[i].a}, {7'd0, ea[i / 4] + 25'(i % 4)});
            chk($sformatf("%s dout[%0d]", nm, i), {24'd0, q[i].d}, {24'd0, w[7:0]});
        end
    endtask

    initial begin
        logic [31:0] rd;
        int base;
        int exp_c[4];
        logic [24:0] exp_a[4];
        logic [7:0]  exp_d[4];

        tbl[0]  = '{1'b0, CTRL,          32'd0,          32'h08, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 32'h0000_0100, 32'h1122_3344,  32'h00, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, CTRL,          32'd0,          32'h08, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, CTRL,          32'h2,          32'h00, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, CTRL,          32'd0,          32'h0A, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 32'h1234_0000, 32'd0,          32'h00, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, CTRL + 32'd4,  32'd0,          32'h00, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, CTRL,          32'h3,          32'h00, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, CTRL,          32'd0,          32'h0F, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, CTRL,          32'h0,          32'h00, 1'b0, 1'b0};
        tbl[10] = '{1'b0, CTRL,          32'd0,          32'h08, 1'b0, 1'b0};

        // reset state
        tick(3);
        chk("rst ioctl_wr", {31'd0, ioctl_wr}, 32'd0);
        chk("rst ioctl_addr", {7'd0, ioctl_addr}, 32'd0);
        chk("rst ioctl_dout", {24'd0, ioctl_dout}, 32'd0);
        chk("rst ram/dl", {30'd0, ioctl_ram, downloading}, 32'd0);
        chk("rst rd_data", bridge_rd_data, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick(1);

        // register table
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].wr) begin
                bwrite(tbl[i].addr, tbl[i].data);
            end else begin
                bread(tbl[i].addr, rd);
                chk($sformatf("tbl[%0d] rd", i), rd, tbl[i].exp_rd);
            end
            chk($sformatf("tbl[%0d] ram", i), {31'd0, ioctl_ram}, {31'd0, tbl[i].exp_ram});
            chk($sformatf("tbl[%0d] dl", i), {31'd0, downloading}, {31'd0, tbl[i].exp_dl});
        end
        chk("ignored write strobes", 32'(q.size()), 32'd0);

        // single word: strobes 2/6/10/14 cycles after the data write
        exp_c = '{2, 6, 10, 14};
        exp_a = '{25'h104, 25'h105, 25'h106, 25'h107};
        exp_d = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        bwrite(CTRL, 32'h1);
        q.delete();
        bwrite(32'h0000_0104, 32'hA1B2_C3D4);
        base = cyc;
        tick(20);
        chk("A count", 32'(q.size()), 32'd4);
        for (int i = 0; i < 4 && i < q.size(); i++) begin
            chk($sformatf("A cyc[%0d]", i), 32'(q[i].c - base), 32'(exp_c[i]));
            chk($sformatf("A addr[%0d]", i), {7'd0, q[i].a}, {7'd0, exp_a[i]});
            chk($sformatf("A dout[%0d]", i), {24'd0, q[i].d}, {24'd0, exp_d[i]});
        end

        // overflow: serialiser busy, five writes into an empty depth-4 FIFO
        q.delete();
        bwrite(32'h0000_01F0, 32'h1020_3040);
        base = cyc;
        ed[0] = 32'h1020_3040; ea[0] = 25'h1F0;
        tick(2);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin ed[i + 1] = 32'h5000_0000 + 32'(i); ea[i + 1] = 25'h200 + 25'(4 * i); end
            bwrite(32'h200 + 32'(4 * i), 32'h5000_0000 + 32'(i));
        end
        bread(CTRL, rd);
        chk("B status ovf", rd, 32'h35);
        bwrite(CTRL, 32'h0);
        bwrite(CTRL, 32'h1);
        bread(CTRL, rd);
        chk("B status ovf cleared", rd, 32'h15);
        tick(90);
        check_stream("B", base, 5);

        // drain after act=0 with three words pending
        q.delete();
        for (int i = 0; i < 3; i++) begin
            ed[i] = 32'hC0C1_C2C3 + 32'(i * 32'h0101_0101);
            ea[i] = 25'h300 + 25'(4 * i);
        end
        bwrite(32'h300, ed[0]);
        base = cyc;
        bwrite(32'h304, ed[1]);
        bwrite(32'h308, ed[2]);
        bwrite(CTRL, 32'h0);
        tick(46);
        chk("C dl in last gap", {31'd0, downloading}, 32'd1);
        tick(1);
        chk("C dl after gap", {31'd0, downloading}, 32'd0);
        check_stream("C", base, 3);
        bread(CTRL, rd);
        chk("C status", rd, 32'h08);

        // reset during EMIT of the second word
        bwrite(CTRL, 32'h3);
        q.delete();
        bwrite(32'h400, 32'h1111_1111);
        bwrite(32'h404, 32'h2222_2222);
        tick(17);
        chk("D in emit", {31'd0, ioctl_wr}, 32'd1);
        chk("D emit addr", {7'd0, ioctl_addr}, 32'h404);
        rst_n = 1'b0;
        #1;
        chk("D rst ioctl_wr", {31'd0, ioctl_wr}, 32'd0);
        chk("D rst ioctl_addr", {7'd0, ioctl_addr}, 32'd0);
        chk("D rst ioctl_dout", {24'd0, ioctl_dout}, 32'd0);
        chk("D rst ram/dl", {30'd0, ioctl_ram, downloading}, 32'd0);
        q.delete();
        @(negedge clk) rst_n = 1'b1;
        tick(40);
        chk("D no strobes", 32'(q.size()), 32'd0);
        bread(CTRL, rd);
        chk("D status", rd, 32'h08);

        // checksum window
        q.delete();
        bwrite(CTRL, 32'h1);
        bwrite(32'h500, 32'h0102_0304);
        bwrite(32'h504, 32'hFFFF_FFFF);
        tick(40);
        chk("E strobes", 32'(q.size()), 32'd8);
        bread(CTRL + 32'd4, rd);
`ifdef JTFRAME_POCKET_DWNLD_CHKSUM_EN
        chk("E checksum", rd, 32'h0406);
`else
        chk("E checksum", rd, 32'h0000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
